spi_slave_tx_sched: RTL and testbench
=====================================

// Module: spi_slave_tx_sched
//
// PURPOSE
//   Scheduler that arbitrates two read-data requesters and sequences the
//   SPI slave transmit shift register. The requesters are register readback
//   (single word, variable bit length) and memory burst readback (N 32-bit
//   words, valid/ready stream). Lives in the sclk domain next to the SPI
//   slave controller. It drives the shifter's counter/data load interface
//   so that consecutive burst words leave MISO with no gap bit.
//
// PARAMETERS
//   MEM_PRIO   0   1: mem wins a simultaneous request; 0: round-robin
//   WCNT_W     16  width of burst word count
//
// PORTS
//   sclk           in   1       SPI clock. Single clock; all state on rising edge.
//   rst            in   1       synchronous, active-high reset (tie to CS deassert)
//   reg_req        in   1       register readback request (level)
//   reg_len        in   8       bits to send minus 1 (0..31)
//   reg_data       in   32      readback word, MSB first, sampled at grant
//   reg_gnt        out  1       1-cycle pulse: reg_data/reg_len captured
//   mem_req        in   1       memory burst request (level)
//   mem_words      in   WCNT_W  burst length in words; 0 treated as 1
//   mem_gnt        out  1       1-cycle pulse: mem_words captured
//   mem_rdata      in   32      burst data word
//   mem_rvalid     in   1       mem_rdata valid
//   mem_rready     out  1       word consumed this cycle (valid & ready)
//   tx_counter     out  8       shifter bit target (bits-1)
//   tx_counter_upd out  1       shifter load strobe
//   tx_data        out  32      shifter parallel data
//   tx_data_valid  out  1       shifter data load strobe
//   tx_done        in   1       shifter last-bit indication
//   busy           out  1       transfer in progress
//   active_src     out  1       0 = reg, 1 = mem (valid while busy)
//   underrun       out  1       sticky: burst word not ready in time
//   sync_err       out  1       sticky: tx_done mismatched internal count
//
// BEHAVIOUR
//   - All outputs registered. Reset values: every output 0, FSM IDLE,
//     bit_cnt = 0, wcnt = 0.
//   - FSM states: IDLE, LOAD, SHIFT.
//     - IDLE: if either req is high, grant (pulse gnt), capture the source,
//       -> LOAD.
//     - Arbitration: both reqs high -> MEM_PRIO=1 picks mem; otherwise the
//       source not served last wins (first tie after reset: reg).
//     - LOAD, reg source: one cycle with tx_counter_upd = tx_data_valid = 1,
//       tx_counter = reg_len, tx_data = captured reg_data; bit_cnt := reg_len
//       -> SHIFT.
//     - LOAD, mem source: wait here until mem_rvalid; mem_rready = 1 in that
//       cycle; then load with tx_counter = 31, tx_data = mem_rdata; -> SHIFT.
//     - SHIFT: bit_cnt decrements by 1 each cycle.
//       - bit_cnt == 0: tx_done must be 1 in this cycle, else set sync_err.
//       - tx_done == 1 with bit_cnt != 0: also sets sync_err.
//     - Back-to-back, mem source: when bit_cnt == 1 and wcnt > 1, the block
//       reloads so the load strobes appear in the cycle where bit_cnt == 0
//       (no idle bit). That load uses the next word if mem_rvalid, else
//       32'h0 with underrun set.
//       - wcnt decrements on each load; the last word -> IDLE after
//         bit_cnt == 0.
//     - reg source: IDLE after bit_cnt == 0.
//   - gnt is only issued in IDLE. A req dropped mid-transfer does not abort.
//   - busy = 1 from the grant cycle through the final bit_cnt == 0 cycle.
//   - rst mid-transfer: immediate return to IDLE. Sticky flags clear;
//     pending mem words are not consumed.
//   - Word-count rule: mem_words is WCNT_W bits; max burst 2^WCNT_W-1 words.
//
// TESTING
//   1. reg_req, reg_len=7, reg_data=32'hA5000000:
//      -> one upd/valid pulse, tx_counter=7; IDLE 9 cycles after grant;
//      sync_err=0.
//   2. mem_req, mem_words=3, rvalid always 1, data 1,2,3:
//      -> 3 loads spaced exactly 32 cycles; 96 bits, no gap; 3 rready pulses.
//   3. Both reqs same cycle, MEM_PRIO=0, after reset -> reg first, then mem;
//      repeat -> mem first.
//   4. Burst of 2, rvalid low when word 2 is due
//      -> 32'h0 loaded, underrun=1 until rst.
//   5. rst asserted at bit 10 of a mem burst -> next cycle all outputs 0,
//      FSM IDLE, no further rready.
//   6. Force tx_done high at bit_cnt=5 -> sync_err=1; mem_words=0 -> single
//      word burst.

Source files
------------

// File: rtl/spi_slave_tx_sched.sv
// SPI slave transmit scheduler: arbitrates register readback against memory
// burst readback and drives the shifter's counter/data load interface so that
// consecutive burst words leave MISO with no gap bit.
`timescale 1ns/1ps
module spi_slave_tx_sched #(
  parameter bit MEM_PRIO = 1'b0,
  parameter int WCNT_W   = 16
) (
  input  logic              sclk_i,
  input  logic              rst_i,
  input  logic              reg_req_i,
  input  logic [7:0]        reg_len_i,
  input  logic [31:0]       reg_data_i,
  output logic              reg_gnt_o,
  input  logic              mem_req_i,
  input  logic [WCNT_W-1:0] mem_words_i,
  output logic              mem_gnt_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  output logic [7:0]        tx_counter_o,
  output logic              tx_counter_upd_o,
  output logic [31:0]       tx_data_o,
  output logic              tx_data_valid_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              active_src_o,
  output logic              underrun_o,
  output logic              sync_err_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SHIFT = 2'd2} state_t;

  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  state_t            state_q, state_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;      // burst words not yet loaded
  logic              last_mem_q, last_mem_d;
  logic              reg_gnt_q, reg_gnt_d;
  logic              mem_gnt_q, mem_gnt_d;
  logic              rready_q, rready_d;
  logic [7:0]        counter_q, counter_d;
  logic              upd_q, upd_d;        // drives both load strobes
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              src_q, src_d;
  logic              underrun_q, underrun_d;
  logic              sync_err_q, sync_err_d;
  logic              pick_mem;
  logic              reload;

  // Tie goes to mem if prioritised, else to whichever source was not served last.
  // last_mem resets to 1 so the first tie after reset goes to reg.
  assign pick_mem = mem_req_i && (!reg_req_i || MEM_PRIO || !last_mem_q);
  assign reload   = src_q && (wcnt_q != '0);

  // State and registered-output update
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      wcnt_q     <= '0;
      last_mem_q <= 1'b1;
      reg_gnt_q  <= 1'b0;
      mem_gnt_q  <= 1'b0;
      rready_q   <= 1'b0;
      counter_q  <= '0;
      upd_q      <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      src_q      <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wcnt_q     <= wcnt_d;
      last_mem_q <= last_mem_d;
      reg_gnt_q  <= reg_gnt_d;
      mem_gnt_q  <= mem_gnt_d;
      rready_q   <= rready_d;
      counter_q  <= counter_d;
      upd_q      <= upd_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      src_q      <= src_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Next-state: grant in IDLE, load/handshake in LOAD, count bits and chain burst words in SHIFT
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wcnt_d     = wcnt_q;
    last_mem_d = last_mem_q;
    reg_gnt_d  = 1'b0;
    mem_gnt_d  = 1'b0;
    rready_d   = 1'b0;
    counter_d  = counter_q;
    upd_d      = 1'b0;
    data_d     = data_q;
    busy_d     = busy_q;
    src_d      = src_q;
    underrun_d = underrun_q;
    sync_err_d = sync_err_q;
    case (state_q)
      S_IDLE: begin
        if (reg_req_i || mem_req_i) begin
          busy_d     = 1'b1;
          src_d      = pick_mem;
          last_mem_d = pick_mem;
          state_d    = S_LOAD;
          if (pick_mem) begin
            mem_gnt_d = 1'b1;
            wcnt_d    = (mem_words_i == '0) ? WCNT_ONE : mem_words_i;
            rready_d  = 1'b1;
          end else begin
            reg_gnt_d = 1'b1;
            upd_d     = 1'b1;
            counter_d = reg_len_i;
            data_d    = reg_data_i;
          end
        end
      end
      S_LOAD: begin
        if (upd_q) begin
          // strobes are on the bus this cycle; shifting starts next cycle
          state_d   = S_SHIFT;
          bit_cnt_d = counter_q;
        end else if (mem_rvalid_i && rready_q) begin
          upd_d     = 1'b1;
          counter_d = 8'd31;
          data_d    = mem_rdata_i;
          wcnt_d    = wcnt_q - WCNT_ONE;
        end else begin
          rready_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if ((bit_cnt_q == 8'd0) != tx_done_i) sync_err_d = 1'b1;
        if (bit_cnt_q != 8'd0) bit_cnt_d = bit_cnt_q - 8'd1;
        // ready is raised one cycle ahead so the handshake lands on bit_cnt == 1
        if (bit_cnt_q == 8'd2 && reload) rready_d = 1'b1;
        if (bit_cnt_q == 8'd1 && reload) begin
          upd_d     = 1'b1;
          counter_d = 8'd31;
          wcnt_d    = wcnt_q - WCNT_ONE;
          if (mem_rvalid_i && rready_q) begin
            data_d = mem_rdata_i;
          end else begin
            data_d     = 32'h0;
            underrun_d = 1'b1;
          end
        end
        if (bit_cnt_q == 8'd0) begin
          if (upd_q) begin
            bit_cnt_d = counter_q;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_gnt_o        = reg_gnt_q;
  assign mem_gnt_o        = mem_gnt_q;
  assign mem_rready_o     = rready_q;
  assign tx_counter_o     = counter_q;
  assign tx_counter_upd_o = upd_q;
  assign tx_data_o        = data_q;
  assign tx_data_valid_o  = upd_q;
  assign busy_o           = busy_q;
  assign active_src_o     = src_q;
  assign underrun_o       = underrun_q;
  assign sync_err_o       = sync_err_q;

endmodule

// File: tb/tb_spi_slave_tx_sched.sv
// Bench for spi_slave_tx_sched: a shifter model answers load strobes with
// tx_done, a stream source feeds burst words, and each transfer is checked
// against load times/data/lengths derived from the transfer rules.
`timescale 1ns/1ps
module tb_spi_slave_tx_sched;

  logic        clk = 1'b0;
  logic        rst, reg_req, mem_req, mem_rvalid, tx_done;
  logic [7:0]  reg_len;
  logic [31:0] reg_data, mem_rdata;
  logic [15:0] mem_words;
  logic        reg_gnt_o, mem_gnt_o, mem_rready_o, tx_counter_upd_o, tx_data_valid_o;
  logic        busy_o, active_src_o, underrun_o, sync_err_o;
  logic [7:0]  tx_counter_o;
  logic [31:0] tx_data_o;

  always #5 clk = ~clk;

  spi_slave_tx_sched #(.MEM_PRIO(1'b0), .WCNT_W(16)) dut (
    .sclk_i(clk), .rst_i(rst),
    .reg_req_i(reg_req), .reg_len_i(reg_len), .reg_data_i(reg_data), .reg_gnt_o(reg_gnt_o),
    .mem_req_i(mem_req), .mem_words_i(mem_words), .mem_gnt_o(mem_gnt_o),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready_o),
    .tx_counter_o(tx_counter_o), .tx_counter_upd_o(tx_counter_upd_o),
    .tx_data_o(tx_data_o), .tx_data_valid_o(tx_data_valid_o), .tx_done_i(tx_done),
    .busy_o(busy_o), .active_src_o(active_src_o), .underrun_o(underrun_o), .sync_err_o(sync_err_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // burst word source: a word is consumed on a cycle with valid & ready
  logic [31:0] words [8];
  int widx = 0, nwords = 0, stall_at = 1000, rready_cnt = 0;
  initial begin
    bit hs;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      hs = mem_rready_o && mem_rvalid;
      if (hs) rready_cnt++;
      @(posedge clk);
      #2;
      if (hs) widx++;
      mem_rvalid = (widx < nwords) && (widx < stall_at);
      mem_rdata  = (widx < 8) ? words[widx] : 32'h0;
    end
  end

  // shifter model: after a load of N, tx_done rises N+1 cycles later
  int force_cyc = -1;
  initial begin
    bit armed;
    int cur;
    armed = 0; cur = 0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        armed = 0; tx_done = 1'b0;
      end else begin
        tx_done = (armed && cur == 0) || (cyc == force_cyc);
        if (armed) begin
          if (cur == 0) armed = 0; else cur--;
        end
        if (tx_counter_upd_o) begin
          armed = 1; cur = int'(tx_counter_o);
        end
      end
    end
  end

  typedef struct {int cyc; logic [7:0] cnt; logic [31:0] data;} load_t;
  load_t loads[$];
  int busy_cnt = 0, rgnt_cnt = 0, mgnt_cnt = 0, strobe_mis = 0;
  initial begin
    load_t l;
    forever begin
      @(negedge clk);
      if (tx_counter_upd_o) begin
        l.cyc = cyc; l.cnt = tx_counter_o; l.data = tx_data_o;
        loads.push_back(l);
      end
      if (tx_counter_upd_o !== tx_data_valid_o) strobe_mis++;
      if (busy_o) busy_cnt++;
      if (reg_gnt_o) rgnt_cnt++;
      if (mem_gnt_o) mgnt_cnt++;
    end
  end

  bit last_mem_m = 1'b1;  // tie-break model: reg wins the first tie after reset

  task automatic check_zero(input string p);
    chk({p, "_reg_gnt"}, reg_gnt_o, 0);
    chk({p, "_mem_gnt"}, mem_gnt_o, 0);
    chk({p, "_rready"}, mem_rready_o, 0);
    chk({p, "_counter"}, tx_counter_o, 0);
    chk({p, "_upd"}, tx_counter_upd_o, 0);
    chk({p, "_data"}, tx_data_o, 0);
    chk({p, "_valid"}, tx_data_valid_o, 0);
    chk({p, "_busy"}, busy_o, 0);
    chk({p, "_src"}, active_src_o, 0);
    chk({p, "_underrun"}, underrun_o, 0);
    chk({p, "_sync_err"}, sync_err_o, 0);
  endtask

  task automatic do_reset(input string p);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero(p);
    rst = 1'b0;
    last_mem_m = 1'b1;
    nwords = 0;
    stall_at = 1000;
  endtask

  task automatic run_txn(input bit rq, input bit mq, input logic [7:0] len, input logic [31:0] rdat,
                         input logic [15:0] nw, input bit seq_words, input int stall,
                         input int force_off, input bit exp_sync);
    int g, n, rr0, exp_rr;
    bit ok, win_mem, src_at_gnt;
    logic [31:0] exp_d;
    @(posedge clk);
    #1;
    loads.delete();
    busy_cnt = 0; rgnt_cnt = 0; mgnt_cnt = 0;
    rr0 = rready_cnt;
    n = (nw == 0) ? 1 : int'(nw);
    for (int i = 0; i < 8; i++) words[i] = seq_words ? 32'(i + 1) : $urandom;
    widx = 0; nwords = n; stall_at = stall;
    reg_len = len; reg_data = rdat; mem_words = nw;
    reg_req = rq; mem_req = mq;
    win_mem = mq && (!rq || !last_mem_m);
    ok = 0; g = 0; src_at_gnt = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (reg_gnt_o || mem_gnt_o) begin
        ok = 1; g = cyc; src_at_gnt = active_src_o;
      end
    end
    chk("gnt_seen", ok, 1);
    reg_req = 1'b0; mem_req = 1'b0;
    if (!ok) return;
    if (force_off >= 0) force_cyc = g + force_off;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy_o) ok = 1;
    end
    chk("busy_drop", ok, 1);
    @(posedge clk);
    #1;
    force_cyc = -1;
    last_mem_m = win_mem;
    chk("reg_gnt_cnt", rgnt_cnt, win_mem ? 0 : 1);
    chk("mem_gnt_cnt", mgnt_cnt, win_mem ? 1 : 0);
    chk("active_src", src_at_gnt, win_mem);
    chk("strobe_pair", strobe_mis, 0);
    if (!win_mem) begin
      chk("reg_loads", loads.size(), 1);
      if (loads.size() > 0) begin
        chk("reg_load_cyc", loads[0].cyc, g);
        chk("reg_load_cnt", loads[0].cnt, len);
        chk("reg_load_data", loads[0].data, rdat);
      end
      chk("reg_busy_len", busy_cnt, int'(len) + 2);
      chk("reg_rready", rready_cnt - rr0, 0);
    end else begin
      chk("mem_loads", loads.size(), n);
      for (int k = 0; k < loads.size() && k < n; k++) begin
        exp_d = (k >= stall) ? 32'h0 : words[k];
        chk($sformatf("mem_load%0d_cyc", k), loads[k].cyc, g + 1 + 32 * k);
        chk($sformatf("mem_load%0d_cnt", k), loads[k].cnt, 31);
        chk($sformatf("mem_load%0d_data", k), loads[k].data, exp_d);
      end
      chk("mem_busy_len", busy_cnt, 2 + 32 * n);
      exp_rr = (stall < n) ? stall : n;
      chk("mem_rready", rready_cnt - rr0, exp_rr);
      chk("mem_underrun", underrun_o, stall < n);
    end
    chk("sync_err", sync_err_o, exp_sync);
  endtask

  initial begin
    int g, rr0;
    bit ok;
    rst = 1'b1; reg_req = 0; mem_req = 0; reg_len = 0; reg_data = 0; mem_words = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // short register readback
    run_txn(1, 0, 8'd7, 32'hA500_0000, 16'd0, 0, 1000, -1, 0);
    for (int i = 0; i < 4; i++)
      run_txn(1, 0, 8'($urandom_range(0, 31)), $urandom, 16'd0, 0, 1000, -1, 0);

    // three-word burst, data 1,2,3
    run_txn(0, 1, 8'd0, 32'h0, 16'd3, 1, 1000, -1, 0);
    for (int i = 0; i < 3; i++)
      run_txn(0, 1, 8'd0, 32'h0, 16'($urandom_range(0, 4)), 0, 1000, -1, 0);

    // simultaneous requests: reg first after reset, then mem
    do_reset("arb_rst");
    run_txn(1, 1, 8'($urandom_range(0, 31)), $urandom, 16'd1, 0, 1000, -1, 0);
    run_txn(1, 1, 8'($urandom_range(0, 31)), $urandom, 16'd2, 0, 1000, -1, 0);
    run_txn(1, 1, 8'($urandom_range(0, 31)), $urandom, 16'd1, 0, 1000, -1, 0);

    // second word not ready in time
    run_txn(0, 1, 8'd0, 32'h0, 16'd2, 0, 1, -1, 0);
    repeat (5) @(negedge clk);
    chk("underrun_sticky", underrun_o, 1);
    do_reset("underrun_rst");

    // reset in the middle of a burst
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) words[i] = $urandom | 32'h1;
    widx = 0; nwords = 3; stall_at = 1000;
    mem_words = 16'd3; mem_req = 1'b1;
    ok = 0; g = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (mem_gnt_o) begin ok = 1; g = cyc; end
    end
    chk("mid_gnt_seen", ok, 1);
    mem_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_busy_before", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    rr0 = rready_cnt;
    loads.delete();
    repeat (40) @(negedge clk);
    chk("mid_no_rready", rready_cnt - rr0, 0);
    chk("mid_no_loads", loads.size(), 0);
    chk("mid_idle", busy_o, 0);
    nwords = 0;
    last_mem_m = 1'b1;

    // spurious tx_done while bit_cnt == 5 (len 12: cycle g+8)
    run_txn(1, 0, 8'd12, $urandom, 16'd0, 0, 1000, 8, 1);
    do_reset("sync_rst");

    // zero word count behaves as a single word
    run_txn(0, 1, 8'd0, 32'h0, 16'd0, 0, 1000, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
